// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with burst ownership: a granted port holds the
// resource for up to weight[n] last-beats, then priority rotates past it.
module wrr_burst_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int WEIGHT_W  = 4,
  localparam int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          last_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic                          gnt_valid_o,
  output logic [ID_W-1:0]               gnt_id_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  valid_q, valid_d;

  logic                  release_c;
  logic                  arb_c;
  logic                  found_c;
  logic [ID_W-1:0]       win_c;
  logic [WEIGHT_W-1:0]   win_weight_c;
  int                    start_c;
  int                    idx_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      credit_q <= '0;
      gnt_q    <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
    end
  end

  // Release check and circular search; after a release the holder goes last.
  always_comb begin
    release_c = 1'b0;
    if (state_q == HOLD) begin
      if (!req_i[id_q]) begin
        release_c = 1'b1;
      end else if (last_i[id_q] && (credit_q == WEIGHT_W'(1))) begin
        release_c = 1'b1;
      end
    end
    arb_c = (state_q == IDLE) || release_c;

    if (state_q == IDLE) begin
      start_c = int'(ptr_q);
    end else begin
      start_c = int'(id_q) + 1;
      if (start_c >= NUM_PORTS) start_c = 0;
    end

    found_c = 1'b0;
    win_c   = '0;
    idx_c   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx_c = start_c + i;
      if (idx_c >= NUM_PORTS) idx_c = idx_c - NUM_PORTS;
      if (!found_c && req_i[idx_c]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx_c);
      end
    end

    win_weight_c = weight_i[int'(win_c)*WEIGHT_W +: WEIGHT_W];
  end

  always_comb begin
    state_d = state_q;
    if (arb_c) begin
      state_d = found_c ? HOLD : IDLE;
    end
  end

  // A zero weight still buys one beat, so credit never loads as 0.
  always_comb begin
    gnt_d    = gnt_q;
    id_d     = id_q;
    valid_d  = valid_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    if (arb_c) begin
      if (found_c) begin
        gnt_d        = '0;
        gnt_d[win_c] = 1'b1;
        id_d         = win_c;
        valid_d      = 1'b1;
        credit_d     = (win_weight_c == '0) ? WEIGHT_W'(1) : win_weight_c;
        if (int'(win_c) == NUM_PORTS - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_c + ID_W'(1);
        end
      end else begin
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    end else if (state_q == HOLD && req_i[id_q] && last_i[id_q] &&
                 (credit_q > WEIGHT_W'(1))) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_id_o    = id_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: a vector table with hand-computed
// grants, then hand-written sole-requester and mid-burst-reset sequences.
module tb_wrr_burst_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [3:0]  last_i;
  logic [15:0] weight_i;
  logic [3:0]  gnt_o;
  logic        gnt_valid_o;
  logic [1:0]  gnt_id_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] weight;
    logic [3:0]  gnt;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[20];

  wrr_burst_arbiter #(.NUM_PORTS(4), .WEIGHT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .last_i      (last_i),
    .weight_i    (weight_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_id_o    (gnt_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge so inputs are stable for the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] req,
                               input logic [3:0] last, input logic [15:0] weight);
    @(negedge clk);
    reset    = rst;
    req_i    = req;
    last_i   = last;
    weight_i = weight;
  endtask

  // Outputs are sampled 1 time unit after the rising edge that registers them.
  task automatic checkOutput(input string name, input logic [3:0] expGnt,
                             input logic [1:0] expId);
    logic expValid;
    expValid = (expGnt != 4'b0000);
    @(posedge clk);
    #1;
    checks++;
    if (gnt_o !== expGnt) begin
      errors++;
      $display("[TB] FAIL %s gnt_o: got %b expected %b", name, gnt_o, expGnt);
    end
    checks++;
    if (gnt_id_o !== expId) begin
      errors++;
      $display("[TB] FAIL %s gnt_id_o: got %0d expected %0d", name, gnt_id_o, expId);
    end
    checks++;
    if (gnt_valid_o !== expValid) begin
      errors++;
      $display("[TB] FAIL %s gnt_valid_o: got %b expected %b", name, gnt_valid_o, expValid);
    end
    checks++;
    if (!$onehot0(gnt_o)) begin
      errors++;
      $display("[TB] FAIL %s onehot: got %b expected at most one bit set", name, gnt_o);
    end
  endtask

  initial begin
    reset    = 1'b1;
    req_i    = 4'b0000;
    last_i   = 4'b0000;
    weight_i = 16'h1111;

    // Reset, priority from ptr 0, handover past the holder.
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 16'h1111, 4'b0000, 2'd0};
    vecs[1]  = '{1'b0, 4'b1010, 4'b0000, 16'h1111, 4'b0010, 2'd1};
    vecs[2]  = '{1'b0, 4'b1010, 4'b0000, 16'h1111, 4'b0010, 2'd1};
    vecs[3]  = '{1'b0, 4'b1010, 4'b0010, 16'h1111, 4'b1000, 2'd3};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 16'h1111, 4'b0000, 2'd0};
    // Round-robin fairness with weight 1 and last held high.
    vecs[5]  = '{1'b0, 4'b1111, 4'b1111, 16'h1111, 4'b0001, 2'd0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 16'h1111, 4'b0010, 2'd1};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 16'h1111, 4'b0100, 2'd2};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 16'h1111, 4'b1000, 2'd3};
    vecs[9]  = '{1'b0, 4'b1111, 4'b1111, 16'h1111, 4'b0001, 2'd0};
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 16'h1111, 4'b0000, 2'd0};
    // Port 2 weight 3; weight change mid-hold and foreign last_i are ignored.
    vecs[11] = '{1'b0, 4'b0100, 4'b0000, 16'h1311, 4'b0100, 2'd2};
    vecs[12] = '{1'b0, 4'b0101, 4'b0100, 16'h1111, 4'b0100, 2'd2};
    vecs[13] = '{1'b0, 4'b0101, 4'b0001, 16'h1111, 4'b0100, 2'd2};
    vecs[14] = '{1'b0, 4'b0101, 4'b0100, 16'h1111, 4'b0100, 2'd2};
    vecs[15] = '{1'b0, 4'b0101, 4'b0101, 16'h1111, 4'b0001, 2'd0};
    // Early drop, then zero weight with same-port re-grant.
    vecs[16] = '{1'b0, 4'b0000, 4'b0000, 16'h1111, 4'b0000, 2'd0};
    vecs[17] = '{1'b0, 4'b0010, 4'b0000, 16'h1101, 4'b0010, 2'd1};
    vecs[18] = '{1'b0, 4'b0010, 4'b0010, 16'h1101, 4'b0010, 2'd1};
    vecs[19] = '{1'b0, 4'b0000, 4'b0000, 16'h1101, 4'b0000, 2'd0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].weight);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id);
    end

    // Sole requester with weight 1 keeps the grant every cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1000, 4'b1000, 16'h1111);
      checkOutput($sformatf("sole%0d", i), 4'b1000, 2'd3);
    end

    // Reset mid-burst drops the grant; arbitration restarts from port 0.
    applyStimulus(1'b0, 4'b1000, 4'b0000, 16'h4111);
    checkOutput("midHold", 4'b1000, 2'd3);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 16'h4111);
    checkOutput("midReset", 4'b0000, 2'd0);
    applyStimulus(1'b0, 4'b1010, 4'b0000, 16'h1111);
    checkOutput("postReset", 4'b0010, 2'd1);
    applyStimulus(1'b0, 4'b1111, 4'b0010, 16'h1111);
    checkOutput("postHandover", 4'b0100, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
